step_sequencer: RTL

STEP_SEQUENCER -- requirements
Module: step_sequencer

---
 rtl/step_sequencer.sv | 105 ++++++++++
 1 files changed

// File: rtl/step_sequencer.sv
// Purpose : instruction step sequencer; run/halt/step/drain FSM driving rIR_data,
//           the step counter and a retired-instruction counter.
// Latency : running follows run one cycle later; the first counter/rIR update
//           lands on the edge after running rises.
// Backpressure: none; halt_req drains the current instruction, step_mode pauses
//           after each retirement, a counter overrun locks up until reset.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   run, halt_req          start/resume and stop-after-current requests
//   step_mode              pause after every retired instruction
//   data_in                opcode byte from memory
//   rIR_enable             decoder: load rIR_data from data_in
//   counter_clear          decoder: return step counter to 0
//   done                   decoder: instruction retires this cycle
//   rIR_data, counter      instruction register and step counter to decoder
//   running                1 in RUN or DRAIN (registered)
//   instr_count            retired-instruction count (wraps)
//   err                    step-counter overrun flag
module step_sequencer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        run,
  input  logic        halt_req,
  input  logic        step_mode,
  input  logic [7:0]  data_in,
  input  logic        rIR_enable,
  input  logic        counter_clear,
  input  logic        done,
  output logic [7:0]  rIR_data,
  output logic [3:0]  counter,
  output logic        running,
  output logic [15:0] instr_count,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    DRAIN = 3'd3,
    ERROR = 3'd4
  } seqState_t;

  seqState_t state;
  seqState_t nextState;
  logic      active;
  logic      overrun;

  // Datapath updates are only honoured while an instruction is executing.
  assign active  = (state == RUN) || (state == DRAIN);
  // Retirement wins over overrun: a done at 4'hF is a legal last step.
  assign overrun = active && (counter == 4'hF) && !counter_clear && !done;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (run) nextState = RUN;
      RUN: begin
        if (overrun)                  nextState = ERROR;
        else if (done && halt_req)    nextState = IDLE;
        else if (done && step_mode)   nextState = PAUSE;
        else if (!done && halt_req)   nextState = DRAIN;
      end
      // halt is already latched by being here; only retirement matters.
      DRAIN: begin
        if (overrun)                  nextState = ERROR;
        else if (done)                nextState = IDLE;
      end
      PAUSE: begin
        if (halt_req)                 nextState = IDLE;
        else if (run)                 nextState = RUN;
      end
      ERROR:                          nextState = ERROR;
      default:                        nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      rIR_data    <= 8'h00;
      counter     <= 4'h0;
      instr_count <= 16'h0000;
      err         <= 1'b0;
      running     <= 1'b0;
    end else begin
      state   <= nextState;
      // Registered decode of the state being entered.
      running <= (nextState == RUN) || (nextState == DRAIN);
      if (active) begin
        if (rIR_enable) rIR_data <= data_in;
        if (done)       instr_count <= instr_count + 16'd1;
        if (overrun) begin
          err     <= 1'b1;
          counter <= 4'hF;
        end else if (counter_clear) begin
          counter <= 4'h0;
        end else begin
          counter <= counter + 4'd1;
        end
      end
    end
  end

endmodule
